// File: rtl/tans_pkg.sv
// Shared tANS/Huffman definitions for the recoder pair.
// Decode table, symbol codes and FSM state encoding.
package tans_pkg;

  localparam int L       = 8;
  localparam int STATE_W = 4;

  typedef enum logic [1:0] {
    SYM_A,
    SYM_B,
    SYM_C
  } sym_e;

  // Huffman codes right-justified, emitted MSB first
  localparam logic [1:0] HUF_A   = 2'b00;
  localparam logic [1:0] HUF_B   = 2'b10;
  localparam logic [1:0] HUF_C   = 2'b11;
  localparam int         HLEN_A  = 1;
  localparam int         HLEN_B  = 2;
  localparam int         HLEN_C  = 2;

  typedef struct packed {
    sym_e               sym;
    logic [1:0]         nb;
    logic [STATE_W-1:0] base;
  } dec_ent_t;

  // Indexed by state - L
  localparam dec_ent_t DEC_TAB [L] = '{
    '{SYM_A, 2'd1, 4'd10},
    '{SYM_A, 2'd1, 4'd12},
    '{SYM_B, 2'd2, 4'd8},
    '{SYM_A, 2'd1, 4'd14},
    '{SYM_A, 2'd0, 4'd8},
    '{SYM_B, 2'd2, 4'd12},
    '{SYM_A, 2'd0, 4'd9},
    '{SYM_C, 2'd3, 4'd8}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIT1,
    S_BIT2,
    S_WAIT,
    S_DONE
  } st_e;

  // Code bit of a symbol: sec=0 first bit, sec=1 second bit
  function automatic logic huf_bit(sym_e s, logic sec);
    logic b;
    b = 1'b0;
    unique case (s)
      SYM_A: b = HUF_A[0];
      SYM_B: b = sec ? HUF_B[0] : HUF_B[1];
      SYM_C: b = sec ? HUF_C[0] : HUF_C[1];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tans_dec_lut.sv
// tANS decode lookup: state -> {symbol, bit count, base}.
// Pure table; swapping DEC_TAB leaves the FSM untouched.
module tans_dec_lut
  import tans_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output sym_e               sym,
  output logic [1:0]         nb,
  output logic [STATE_W-1:0] base
);

  dec_ent_t e;

  // Select the entry whose state matches
  always_comb begin
    e = DEC_TAB[0];
    for (int i = 0; i < L; i++) begin
      if (state == STATE_W'(L + i)) e = DEC_TAB[i];
    end
  end

  assign sym  = e.sym;
  assign nb   = e.nb;
  assign base = e.base;

endmodule

// File: rtl/tans_hf_recoder.sv
// tANS chunk stream -> serial Huffman bits, forward order.
// One code bit per cycle; reports recovered start state.
module tans_hf_recoder #(
  parameter int CNT_W   = 8,
  parameter int STATE_W = 4
) (
  input  logic               PHI,
  input  logic               RST,
  input  logic               I_F,
  input  logic [STATE_W-1:0] init_state,
  input  logic [CNT_W-1:0]   n_symbols,
  input  logic               chunk_valid,
  output logic               chunk_ready,
  input  logic [1:0]         chunk_nbits,
  input  logic [2:0]         chunk_bits,
  output logic               o_bit,
  output logic               o_valid,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [STATE_W-1:0] end_state
);

  import tans_pkg::*;

  st_e                st_q, st_d;
  logic [STATE_W-1:0] x_q, x_d;
  logic [STATE_W-1:0] end_q, end_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  sym_e               sym;
  logic [1:0]         nb;
  logic [STATE_W-1:0] base;
  logic [2:0]         mask;
  logic [STATE_W-1:0] x_nxt;
  logic               take;

  tans_dec_lut u_lut (
    .state (x_q),
    .sym   (sym),
    .nb    (nb),
    .base  (base)
  );

  // Table nb decides how many chunk bits count
  assign mask  = 3'((4'd1 << nb) - 4'd1);
  assign x_nxt = base + STATE_W'(chunk_bits & mask);

  // Next-state, datapath updates and outputs
  always_comb begin
    st_d        = st_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    end_d       = end_q;
    err_d       = err_q;
    o_valid     = 1'b0;
    o_bit       = 1'b0;
    chunk_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    take        = 1'b0;
    unique case (st_q)
      S_IDLE, S_DONE: begin
        done = (st_q == S_DONE);
        if (I_F) begin
          x_d   = init_state;
          cnt_d = n_symbols;
          err_d = 1'b0;
          if (n_symbols == '0) begin
            st_d  = S_DONE;
            end_d = init_state;
          end else begin
            st_d = S_BIT1;
          end
        end
      end
      S_BIT1: begin
        busy    = 1'b1;
        o_valid = 1'b1;
        o_bit   = huf_bit(sym, 1'b0);
        if (sym == SYM_A) begin
          chunk_ready = 1'b1;
          if (chunk_valid) take = 1'b1;
          else             st_d = S_WAIT;
        end else begin
          st_d = S_BIT2;
        end
      end
      S_BIT2: begin
        busy        = 1'b1;
        o_valid     = 1'b1;
        o_bit       = huf_bit(sym, 1'b1);
        chunk_ready = 1'b1;
        if (chunk_valid) take = 1'b1;
        else             st_d = S_WAIT;
      end
      S_WAIT: begin
        busy        = 1'b1;
        chunk_ready = 1'b1;
        if (chunk_valid) take = 1'b1;
      end
      default: st_d = S_IDLE;
    endcase
    if (take) begin
      x_d   = x_nxt;
      cnt_d = cnt_q - 1'b1;
      if (chunk_nbits != nb) err_d = 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        st_d  = S_DONE;
        end_d = x_nxt;
      end else begin
        st_d = S_BIT1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge PHI) begin
    if (RST) begin
      st_q  <= S_IDLE;
      x_q   <= '0;
      cnt_q <= '0;
      end_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      cnt_q <= cnt_d;
      end_q <= end_d;
      err_q <= err_d;
    end
  end

  assign err       = err_q;
  assign end_state = end_q;

endmodule

// File: tb/tb_tans_hf_recoder.sv
// Directed bench for tans_hf_recoder.
// Inputs change 1ns after posedge; outputs checked mid-cycle.
module tb_tans_hf_recoder;

  logic       PHI = 1'b0;
  logic       RST;
  logic       I_F;
  logic [3:0] init_state;
  logic [7:0] n_symbols;
  logic       chunk_valid;
  logic       chunk_ready;
  logic [1:0] chunk_nbits;
  logic [2:0] chunk_bits;
  logic       o_bit;
  logic       o_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] end_state;

  int n_chk  = 0;
  int n_fail = 0;

  tans_hf_recoder #(.CNT_W(8), .STATE_W(4)) dut (
    .PHI         (PHI),
    .RST         (RST),
    .I_F         (I_F),
    .init_state  (init_state),
    .n_symbols   (n_symbols),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_nbits (chunk_nbits),
    .chunk_bits  (chunk_bits),
    .o_bit       (o_bit),
    .o_valid     (o_valid),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .end_state   (end_state)
  );

  always #5 PHI = ~PHI;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PHI);
    #1;
  endtask

  task automatic load(input logic [3:0] st, input logic [7:0] n);
    I_F         = 1'b1;
    init_state  = st;
    n_symbols   = n;
    chunk_valid = 1'b0;
    tick();
    I_F = 1'b0;
  endtask

  // A cycle that emits a code bit
  task automatic bit_cyc(input string tag, input logic eb,
                         input logic er, input logic cv,
                         input logic [1:0] nbv, input logic [2:0] bv);
    chunk_valid = cv;
    chunk_nbits = nbv;
    chunk_bits  = bv;
    #1;
    chk({tag, "_v"},   o_valid,     1'b1);
    chk({tag, "_b"},   o_bit,       eb);
    chk({tag, "_rdy"}, chunk_ready, er);
    chk({tag, "_bsy"}, busy,        1'b1);
    tick();
  endtask

  // A stalled cycle with no bit out
  task automatic wait_cyc(input string tag, input logic cv,
                          input logic [1:0] nbv, input logic [2:0] bv);
    chunk_valid = cv;
    chunk_nbits = nbv;
    chunk_bits  = bv;
    #1;
    chk({tag, "_v"},   o_valid,     1'b0);
    chk({tag, "_rdy"}, chunk_ready, 1'b1);
    chk({tag, "_bsy"}, busy,        1'b1);
    tick();
  endtask

  task automatic chk_done(input string tag, input logic [3:0] es,
                          input logic e);
    chunk_valid = 1'b0;
    #1;
    chk({tag, "_done"}, done,      1'b1);
    chk({tag, "_bsy"},  busy,      1'b0);
    chk({tag, "_v"},    o_valid,   1'b0);
    chk({tag, "_end"},  end_state, es);
    chk({tag, "_err"},  err,       e);
  endtask

  task automatic chk_zero(input string tag);
    #1;
    chk({tag, "_v"},   o_valid,     1'b0);
    chk({tag, "_b"},   o_bit,       1'b0);
    chk({tag, "_rdy"}, chunk_ready, 1'b0);
    chk({tag, "_bsy"}, busy,        1'b0);
    chk({tag, "_done"}, done,       1'b0);
    chk({tag, "_err"}, err,         1'b0);
    chk({tag, "_end"}, end_state,   4'd0);
  endtask

  task automatic seq_a3(input string tag);
    load(4'd12, 8'd3);
    bit_cyc({tag, "1"}, 1'b0, 1'b1, 1'b1, 2'd0, 3'b110);
    bit_cyc({tag, "2"}, 1'b0, 1'b1, 1'b1, 2'd1, 3'b111);
    bit_cyc({tag, "3"}, 1'b0, 1'b1, 1'b1, 2'd1, 3'b000);
    chk_done({tag, "d"}, 4'd14, 1'b0);
  endtask

  initial begin
    RST         = 1'b1;
    I_F         = 1'b0;
    init_state  = '0;
    n_symbols   = '0;
    chunk_valid = 1'b0;
    chunk_nbits = '0;
    chunk_bits  = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      I_F         = 1'($urandom);
      init_state  = 4'($urandom);
      n_symbols   = 8'($urandom);
      chunk_valid = 1'($urandom);
      chunk_nbits = 2'($urandom);
      chunk_bits  = 3'($urandom);
      tick();
      chk_zero($sformatf("rst%0d", i));
    end
    RST = 1'b0;
    I_F = 1'b0;
    chunk_valid = 1'b0;
    tick();

    seq_a3("a3_");

    load(4'd15, 8'd2);
    bit_cyc("cb1", 1'b1, 1'b0, 1'b1, 2'd3, 3'b101);
    bit_cyc("cb2", 1'b1, 1'b1, 1'b1, 2'd3, 3'b101);
    bit_cyc("cb3", 1'b1, 1'b0, 1'b1, 2'd2, 3'b010);
    bit_cyc("cb4", 1'b0, 1'b1, 1'b1, 2'd2, 3'b010);
    chk_done("cbd", 4'd14, 1'b0);

    load(4'd15, 8'd2);
    bit_cyc("st1", 1'b1, 1'b0, 1'b0, 2'd3, 3'b101);
    bit_cyc("st2", 1'b1, 1'b1, 1'b0, 2'd3, 3'b101);
    wait_cyc("stw1", 1'b0, 2'd3, 3'b101);
    wait_cyc("stw2", 1'b0, 2'd3, 3'b101);
    wait_cyc("stw3", 1'b1, 2'd3, 3'b101);
    bit_cyc("st3", 1'b1, 1'b0, 1'b0, 2'd2, 3'b010);
    bit_cyc("st4", 1'b0, 1'b1, 1'b0, 2'd2, 3'b010);
    wait_cyc("stw4", 1'b0, 2'd2, 3'b010);
    wait_cyc("stw5", 1'b0, 2'd2, 3'b010);
    wait_cyc("stw6", 1'b1, 2'd2, 3'b010);
    chk_done("std", 4'd14, 1'b0);

    load(4'd12, 8'd1);
    bit_cyc("mm1", 1'b0, 1'b1, 1'b1, 2'd1, 3'b001);
    chk_done("mmd", 4'd8, 1'b1);
    load(4'd9, 8'd0);
    chk_done("z0d", 4'd9, 1'b0);
    tick();
    chk_done("z1d", 4'd9, 1'b0);

    load(4'd15, 8'd2);
    bit_cyc("rs1", 1'b1, 1'b0, 1'b1, 2'd3, 3'b101);
    RST         = 1'b1;
    chunk_valid = 1'b0;
    #1;
    chk("rs2_v", o_valid, 1'b1);
    chk("rs2_b", o_bit,   1'b1);
    tick();
    RST = 1'b0;
    chk_zero("rsz");
    tick();
    chk_zero("rsi");
    seq_a3("ra3_");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
